// File: rtl/cmd_pkg.sv
// cmd_pkg: command-link opcodes, acknowledge byte and remote-side FSM states.
package cmd_pkg;
  localparam logic [7:0] REQ_BATT  = 8'h01;
  localparam logic [7:0] SET_PTCH  = 8'h02;
  localparam logic [7:0] SET_ROLL  = 8'h03;
  localparam logic [7:0] SET_YAW   = 8'h04;
  localparam logic [7:0] SET_THRST = 8'h05;
  localparam logic [7:0] CALIBRATE = 8'h06;
  localparam logic [7:0] EMER_LAND = 8'h07;
  localparam logic [7:0] MTRS_OFF  = 8'h08;
  localparam logic [7:0] POS_ACK   = 8'hA5;
  typedef enum logic [2:0] {IDLE, TX_CMD, TX_HI, TX_LO, WAIT_RESP} rc_state_t;
endpackage

// File: rtl/resp_tmr.sv
// resp_tmr: saturating response-window counter; expired holds at terminal count.
module resp_tmr #(
  parameter logic [24:0] TMO_CYCLES = 25'd25_000_000,
  localparam int W = $clog2(TMO_CYCLES)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);
  logic [W-1:0] cnt;
  assign expired = cnt == W'(TMO_CYCLES - 25'd1);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else if (clr) cnt <= '0;
    else if (en && !expired) cnt <= cnt + 1'b1;
endmodule

// File: rtl/remote_comm.sv
// remote_comm: sends opcode/data-hi/data-lo over the UART, then waits for a
// one-byte response or a timeout and presents the result to the host.
module remote_comm
  import cmd_pkg::*;
#(
  parameter logic [24:0] TMO_CYCLES = 25'd25_000_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        snd_cmd,
  input  logic [7:0]  cmd,
  input  logic [15:0] data,
  input  logic        tx_done,
  input  logic        rx_rdy,
  input  logic [7:0]  rx_data,
  output logic        trmt,
  output logic [7:0]  tx_data,
  output logic        clr_rx_rdy,
  output logic        busy,
  output logic [7:0]  resp,
  output logic        resp_rdy,
  output logic        pos_ack,
  output logic        timeout
);
  rc_state_t state, nxt;
  logic [15:0] data_q;
  logic [7:0] tx_data_d, resp_d;
  logic trmt_d, clr_d, busy_d, resp_rdy_d, pos_ack_d, timeout_d;
  logic expired, rx_new, got, tmo;
  // a byte whose clear is already in flight is the one just consumed, not a new one
  assign rx_new = rx_rdy && !clr_rx_rdy;
  assign got = state == WAIT_RESP && rx_new;
  assign tmo = state == WAIT_RESP && expired && !rx_new;
  resp_tmr #(.TMO_CYCLES(TMO_CYCLES)) u_tmr (
    .clk(clk),
    .rst_n(rst_n),
    .clr(state != WAIT_RESP),
    .en(state == WAIT_RESP),
    .expired(expired)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      data_q <= '0;
      trmt <= 1'b0;
      tx_data <= '0;
      clr_rx_rdy <= 1'b0;
      busy <= 1'b0;
      resp <= '0;
      resp_rdy <= 1'b0;
      pos_ack <= 1'b0;
      timeout <= 1'b0;
    end else begin
      state <= nxt;
      if (state == IDLE && snd_cmd) data_q <= data;
      trmt <= trmt_d;
      tx_data <= tx_data_d;
      clr_rx_rdy <= clr_d;
      busy <= busy_d;
      resp <= resp_d;
      resp_rdy <= resp_rdy_d;
      pos_ack <= pos_ack_d;
      timeout <= timeout_d;
    end
  // trmt marks the entry cycle, so a tx_done coincident with it is ignored
  always_comb begin
    nxt = state;
    case (state)
      IDLE:      if (snd_cmd) nxt = TX_CMD;
      TX_CMD:    if (tx_done && !trmt) nxt = TX_HI;
      TX_HI:     if (tx_done && !trmt) nxt = TX_LO;
      TX_LO:     if (tx_done && !trmt) nxt = WAIT_RESP;
      WAIT_RESP: if (got || tmo) nxt = IDLE;
      default:   nxt = IDLE;
    endcase
  end
  always_comb begin
    trmt_d = nxt != state && nxt != IDLE && nxt != WAIT_RESP;
    tx_data_d = !trmt_d ? tx_data :
                state == IDLE ? cmd :
                state == TX_CMD ? data_q[15:8] : data_q[7:0];
    clr_d = rx_new;
    busy_d = state != IDLE || snd_cmd;
    resp_rdy_d = got;
    timeout_d = tmo;
    resp_d = got ? rx_data : resp;
    pos_ack_d = got ? rx_data == POS_ACK : tmo ? 1'b0 : pos_ack;
  end
endmodule

// File: tb/tb_remote_comm.sv
// tb_remote_comm: random and directed frames against a UART environment model
// and a frame-level reference of bytes sent, response and timeout timing.
module tb_remote_comm;
  import cmd_pkg::*;
  logic clk = 0, rst_n = 0, snd_cmd = 0, tx_done = 0, rx_rdy = 0;
  logic [7:0] cmd = 0, rx_data = 0;
  logic [15:0] data = 0;
  logic trmt, clr_rx_rdy, busy, resp_rdy, pos_ack, timeout;
  logic [7:0] tx_data, resp;
  int n_chk = 0, n_fail = 0, cyc = 0, tx_cnt = 0, done_edge = 0;
  int n_rr = 0, n_to = 0, to_cyc = 0;
  logic [7:0] sent[$];
  logic [7:0] exp_resp = 0;
  logic exp_ack = 0;

  always #5 clk = ~clk;

  remote_comm #(.TMO_CYCLES(25'd16)) dut (
    .clk(clk), .rst_n(rst_n), .snd_cmd(snd_cmd), .cmd(cmd), .data(data),
    .tx_done(tx_done), .rx_rdy(rx_rdy), .rx_data(rx_data), .trmt(trmt),
    .tx_data(tx_data), .clr_rx_rdy(clr_rx_rdy), .busy(busy), .resp(resp),
    .resp_rdy(resp_rdy), .pos_ack(pos_ack), .timeout(timeout)
  );

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    n_chk++;
    assert (o === e) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, o, e);
    end
  endtask

  // one clock with the UART tx/rx environment stepped just after the edge
  task automatic tick;
    logic c;
    c = clr_rx_rdy;
    @(posedge clk);
    cyc++;
    #1;
    tx_done = 0;
    snd_cmd = 0;
    if (c) rx_rdy = 0;
    if (tx_cnt > 0) begin
      tx_cnt--;
      if (tx_cnt == 0) begin
        tx_done = 1;
        done_edge = cyc + 1;
      end
    end
    if (trmt) begin
      sent.push_back(tx_data);
      tx_cnt = 10;
    end
    if (resp_rdy) n_rr++;
    if (timeout) begin
      n_to++;
      to_cyc = cyc;
    end
  endtask

  // kind: 0 response after dly cycles, 1 silent airframe, 2 response on expiry edge
  task automatic run_frame(input logic [7:0] c, input logic [15:0] d, input int kind,
                           input logic [7:0] rb, input int dly, input bit xtra);
    int lim;
    sent.delete();
    n_rr = 0;
    n_to = 0;
    cmd = c;
    data = d;
    snd_cmd = 1;
    tick;
    chk("acc_busy", busy, 1);
    chk("acc_trmt", trmt, 1);
    chk("acc_txd", tx_data, c);
    if (xtra) begin
      rx_rdy = 1;
      rx_data = 8'h77;
      tick;
      chk("stale_clr", clr_rx_rdy, 1);
      chk("stale_rdy", resp_rdy, 0);
      chk("stale_resp", resp, exp_resp);
    end
    lim = 0;
    while (!(sent.size() == 3 && tx_done) && lim < 200) begin
      if (xtra && sent.size() == 2 && tx_cnt == 5) begin
        snd_cmd = 1;
        cmd = SET_THRST;
      end
      tick;
      lim++;
    end
    chk("frame_bound", lim < 200, 1);
    if (kind == 1) begin
      lim = 0;
      while (n_to == 0 && lim < 40) begin
        tick;
        lim++;
      end
      exp_ack = 0;
      chk("tmo_delay", to_cyc - done_edge, 16);
      chk("tmo_pulse", timeout, 1);
      chk("tmo_resp", resp, exp_resp);
      chk("tmo_ack", pos_ack, 0);
      chk("tmo_rr", resp_rdy, 0);
    end else begin
      repeat (kind == 2 ? 16 : dly) tick;
      rx_rdy = 1;
      rx_data = rb;
      tick;
      exp_resp = rb;
      exp_ack = rb == POS_ACK;
      chk("rsp_rdy", resp_rdy, 1);
      chk("rsp_clr", clr_rx_rdy, 1);
      chk("rsp_tmo", timeout, 0);
      chk("rsp_val", resp, exp_resp);
      chk("rsp_ack", pos_ack, exp_ack);
    end
    chk("hold_busy", busy, 1);
    tick;
    chk("busy_fall", busy, 0);
    chk("pulse_rr", resp_rdy, 0);
    chk("pulse_to", timeout, 0);
    repeat (3) tick;
    chk("n_bytes", sent.size(), 3);
    if (sent.size() == 3) begin
      chk("byte_cmd", sent[0], c);
      chk("byte_hi", sent[1], d[15:8]);
      chk("byte_lo", sent[2], d[7:0]);
    end
    chk("n_resp_rdy", n_rr, kind != 1);
    chk("n_timeout", n_to, kind == 1);
    chk("idle_resp", resp, exp_resp);
    chk("idle_ack", pos_ack, exp_ack);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_trmt"}, trmt, 0);
    chk({tag, "_txd"}, tx_data, 0);
    chk({tag, "_clr"}, clr_rx_rdy, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_resp"}, resp, 0);
    chk({tag, "_rr"}, resp_rdy, 0);
    chk({tag, "_ack"}, pos_ack, 0);
    chk({tag, "_tmo"}, timeout, 0);
  endtask

  initial begin
    int lim;
    #1;
    chk_reset_vals("rst");
    repeat (2) tick;
    #2 rst_n = 1;
    tick;
    run_frame(SET_PTCH, 16'h1234, 0, POS_ACK, 3, 0);
    run_frame(REQ_BATT, 16'h0000, 0, 8'hC3, 5, 0);
    run_frame(SET_ROLL, 16'hBEEF, 1, 8'h00, 0, 0);
    run_frame(SET_YAW, 16'h5A5A, 2, 8'h3C, 0, 0);
    run_frame(SET_PTCH, 16'hCAFE, 0, POS_ACK, 1, 1);
    // reset while the low data byte is in flight
    sent.delete();
    cmd = MTRS_OFF;
    data = 16'h9876;
    snd_cmd = 1;
    lim = 0;
    tick;
    while (sent.size() < 3 && lim < 200) begin
      tick;
      lim++;
    end
    chk("mid_bound", lim < 200, 1);
    #3 rst_n = 0;
    #1;
    chk_reset_vals("mid");
    tx_cnt = 0;
    tx_done = 0;
    rx_rdy = 0;
    exp_resp = 0;
    exp_ack = 0;
    #2 rst_n = 1;
    tick;
    run_frame(EMER_LAND, 16'h0F0F, 0, 8'h11, 4, 0);
    for (int i = 0; i < 20; i++)
      run_frame(8'($urandom_range(1, 8)), 16'($urandom), int'($urandom_range(0, 2)),
                $urandom_range(0, 2) == 0 ? POS_ACK : 8'($urandom),
                int'($urandom_range(1, 12)), 1'($urandom_range(0, 1)));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, observed cycle %0d expected end", cyc);
    $fatal(1, "watchdog");
  end
endmodule
